// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
//   Shared types and constants for the two-port SDRAM arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, ACCEPT, WAIT_DONE)
//   - PORT_D/PORT_I : owner index of the data port (0) and instruction-fetch port (1)
//   - DEF_* : default address, data and watchdog widths
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCEPT    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  localparam int DEF_ADDR_W    = 24;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_TIMEOUT_W = 10;

endpackage

// File: rtl/sdram_arb_port.sv
// sdram_arb_port
//   Per-port completion register. Turns the arbiter's one-cycle completion
//   strobes into registered pN_done / pN_err pulses and holds the last read
//   word until the next successful read on this port.
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   done_set    : access owned by this port completes this cycle
//   err_set     : completion is a watchdog abort
//   rdata_load  : read data captured this cycle
//   rdata_in    : read data from the controller
//   done, err   : registered completion pulse and its error qualifier
//   rdata       : held read data
module sdram_arb_port
  import sdram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_set,
  input  logic              err_set,
  input  logic              rdata_load,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      done <= done_set;
      err  <= err_set;
      if (rdata_load) rdata <= rdata_in;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares the single-access SDRAM controller between port 0 (data load/store)
//   and port 1 (instruction fetch). One access is outstanding at a time: a
//   request is latched, issued with a one-cycle m_read_req/m_write_req strobe,
//   held stable on m_addr/m_wdata and completed back to its owner.
//   A watchdog aborts an access that does not finish within 2**TIMEOUT_W-1
//   cycles of issue, reporting pN_done with pN_err.
// Configuration
//   SDRAM_ARB_RR_EN : round-robin on ties (port not served last wins).
//                     Undefined: fixed priority, port 0 over port 1.
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   pN_req/we/addr/wdata        : port N request (level) and its attributes
//   pN_gnt                      : pulse, request latched
//   pN_done/pN_err/pN_rdata     : completion pulse, abort flag, held read data
//   m_addr/m_wdata              : controller address/data, stable per access
//   m_read_req/m_write_req      : one-cycle controller strobes
//   m_busy/m_read_ready/m_rdata : controller status and read return
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read_req,
  output logic              m_write_req,
  input  logic              m_busy,
  input  logic              m_read_ready,
  input  logic [DATA_W-1:0] m_rdata
);

  // Expiry is detected one count early so the abort pulse appears in the
  // cycle the counter reaches its all-ones value.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  arb_state_e           state;
  logic                 owner;
  logic                 we_q;
  logic [TIMEOUT_W-1:0] wdog;

  logic                 any_req;
  logic                 sel;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  logic                 rd_fin;
  logic                 wr_fin;
  logic                 wd_exp;
  logic                 fin;

`ifdef SDRAM_ARB_RR_EN
  logic                 last_port;
`endif

  // Winner select
  always_comb begin
    any_req = p0_req | p1_req;
`ifdef SDRAM_ARB_RR_EN
    if (p0_req && p1_req) sel = ~last_port;
    else                  sel = p0_req ? PORT_D : PORT_I;
`else
    sel = p0_req ? PORT_D : PORT_I;
`endif
    sel_we    = (sel == PORT_I) ? p1_we    : p0_we;
    sel_addr  = (sel == PORT_I) ? p1_addr  : p0_addr;
    sel_wdata = (sel == PORT_I) ? p1_wdata : p0_wdata;
  end

  // Completion conditions; a real completion always beats a coincident expiry
  always_comb begin
    rd_fin = (state == WAIT_DONE) && !we_q && m_read_ready;
    wr_fin = (state == WAIT_DONE) &&  we_q && !m_busy;
    wd_exp = ((state == ACCEPT) || (state == WAIT_DONE)) && (wdog == WDOG_LAST)
             && !rd_fin && !wr_fin;
    fin    = rd_fin | wr_fin | wd_exp;
  end

  // Issue / wait / complete FSM with its registered strobes and m_* latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= PORT_D;
      we_q        <= 1'b0;
      wdog        <= '0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_read_req  <= 1'b0;
      m_write_req <= 1'b0;
      p0_gnt      <= 1'b0;
      p1_gnt      <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_port   <= PORT_I;
`endif
    end else begin
      m_read_req  <= 1'b0;
      m_write_req <= 1'b0;
      p0_gnt      <= 1'b0;
      p1_gnt      <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (!m_busy && any_req) begin
            owner       <= sel;
            we_q        <= sel_we;
            m_addr      <= sel_addr;
            m_wdata     <= sel_wdata;
            m_read_req  <= ~sel_we;
            m_write_req <= sel_we;
            p0_gnt      <= (sel == PORT_D);
            p1_gnt      <= (sel == PORT_I);
`ifdef SDRAM_ARB_RR_EN
            last_port   <= sel;
`endif
            state       <= ACCEPT;
          end
        end
        ACCEPT: begin
          wdog <= wdog + WDOG_ONE;
          if (wd_exp)      state <= IDLE;
          else if (m_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          wdog <= wdog + WDOG_ONE;
          if (fin) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-port completion registers
  sdram_arb_port #(.DATA_W(DATA_W)) u_port0 (
    .clk        (clk),
    .rst        (rst),
    .done_set   (fin    && (owner == PORT_D)),
    .err_set    (wd_exp && (owner == PORT_D)),
    .rdata_load (rd_fin && (owner == PORT_D)),
    .rdata_in   (m_rdata),
    .done       (p0_done),
    .err        (p0_err),
    .rdata      (p0_rdata)
  );

  sdram_arb_port #(.DATA_W(DATA_W)) u_port1 (
    .clk        (clk),
    .rst        (rst),
    .done_set   (fin    && (owner == PORT_I)),
    .err_set    (wd_exp && (owner == PORT_I)),
    .rdata_load (rd_fin && (owner == PORT_I)),
    .rdata_in   (m_rdata),
    .done       (p1_done),
    .err        (p1_err),
    .rdata      (p1_rdata)
  );

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [23:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
  logic [15:0] p0_rdata, p1_rdata;
  logic [23:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_read_req, m_write_req;
  logic        m_busy;
  logic        m_read_ready = 1'b0;
  logic [15:0] m_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read_req(m_read_req), .m_write_req(m_write_req),
    .m_busy(m_busy), .m_read_ready(m_read_ready), .m_rdata(m_rdata)
  );

  // Controller model: busy from strobe until mdl_lat cycles later; read_ready
  // pulses as busy drops. hang freezes it busy; force_busy mimics init/refresh.
  logic mdl_busy = 1'b0;
  logic mdl_rd = 1'b0;
  logic hang = 1'b0;
  logic force_busy = 1'b0;
  int   mdl_cnt = 0;
  int   mdl_lat = 3;

  assign m_busy = mdl_busy | force_busy;

  always @(posedge clk) begin
    m_read_ready <= 1'b0;
    if (m_read_req || m_write_req) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= mdl_lat;
      mdl_rd   <= m_read_req;
    end else if (mdl_busy && !hang) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        mdl_busy     <= 1'b0;
        m_read_ready <= mdl_rd;
      end
    end
  end

  // Event monitor, sampled on the inactive edge
  int n_gnt0, n_gnt1, n_done0, n_done1, n_rd, n_wr;
  int order[$];

  always @(negedge clk) begin
    if (p0_gnt)      begin n_gnt0++; order.push_back(0); end
    if (p1_gnt)      begin n_gnt1++; order.push_back(1); end
    if (p0_done)     n_done0++;
    if (p1_done)     n_done1++;
    if (m_read_req)  n_rd++;
    if (m_write_req) n_wr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_gnt0 = 0; n_gnt1 = 0; n_done0 = 0; n_done1 = 0; n_rd = 0; n_wr = 0;
    order.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_counts();
  endtask

  // which: 0=p0_gnt 1=p1_gnt 2=p0_done 3=p1_done
  task automatic wait_for(input int which, input int bound, output bit ok, output int n);
    logic s;
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      n++;
      case (which)
        0: s = p0_gnt;
        1: s = p1_gnt;
        2: s = p0_done;
        default: s = p1_done;
      endcase
      if (s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err, m_read_req, m_write_req} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000000",
               {p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err, m_read_req, m_write_req});
    end
    checks++;
    if ({p0_rdata, p1_rdata, m_addr, m_wdata} !== 72'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", {p0_rdata, p1_rdata, m_addr, m_wdata});
    end
    rst = 1'b0;
    clear_counts();
  endtask

  task automatic test_read();
    bit ok; int n;
    reset_dut();
    m_rdata = 16'hBEEF;
    p0_we = 1'b0; p0_addr = 24'h123456; p0_req = 1'b1;
    wait_for(0, 20, ok, n);
    checks++;
    if (!ok || m_read_req !== 1'b1 || m_write_req !== 1'b0 || m_addr !== 24'h123456) begin
      failures++;
      $display("FAIL read_issue ok=%0d rd=%b wr=%b addr=%h want ok=1 rd=1 wr=0 addr=123456",
               ok, m_read_req, m_write_req, m_addr);
    end
    p0_req = 1'b0;
    p0_addr = 24'h0;
    wait_for(2, 30, ok, n);
    checks++;
    if (!ok || n != 5) begin
      failures++;
      $display("FAIL read_latency ok=%0d cycles=%0d want ok=1 cycles=5", ok, n);
    end
    checks++;
    if (p0_rdata !== 16'hBEEF || p0_err !== 1'b0) begin
      failures++;
      $display("FAIL read_data rdata=%h err=%b want rdata=beef err=0", p0_rdata, p0_err);
    end
    repeat (5) tick();
    checks++;
    if (n_rd != 1 || n_wr != 0 || n_done0 != 1 || n_gnt0 != 1) begin
      failures++;
      $display("FAIL read_counts rd=%0d wr=%0d done0=%0d gnt0=%0d want 1 0 1 1", n_rd, n_wr, n_done0, n_gnt0);
    end
    checks++;
    if (n_gnt1 != 0 || n_done1 != 0 || p1_rdata !== 16'h0 || p1_err !== 1'b0) begin
      failures++;
      $display("FAIL read_p1_quiet gnt1=%0d done1=%0d rdata1=%h want 0 0 0", n_gnt1, n_done1, p1_rdata);
    end
  endtask

  task automatic test_write();
    bit ok; int n; int t; int fall_t; logic seen_busy; int bad;
    reset_dut();
    p1_we = 1'b1; p1_addr = 24'h000010; p1_wdata = 16'hA5A5; p1_req = 1'b1;
    wait_for(1, 20, ok, n);
    checks++;
    if (!ok || m_write_req !== 1'b1 || m_read_req !== 1'b0 || m_addr !== 24'h000010 || m_wdata !== 16'hA5A5) begin
      failures++;
      $display("FAIL write_issue ok=%0d wr=%b rd=%b addr=%h wdata=%h want 1 1 0 000010 a5a5",
               ok, m_write_req, m_read_req, m_addr, m_wdata);
    end
    p1_req = 1'b0; p1_addr = 24'hFFFFFF; p1_wdata = 16'h0000; p1_we = 1'b0;
    t = 0; fall_t = -1; seen_busy = 1'b0; bad = 0; ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      t++;
      if (p1_done) begin ok = 1'b1; break; end
      if (m_busy) seen_busy = 1'b1;
      if (seen_busy && !m_busy && fall_t < 0) fall_t = t;
      if (m_addr !== 24'h000010 || m_wdata !== 16'hA5A5) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL write_stable changed_cycles=%0d want 0", bad);
    end
    checks++;
    if (!ok || fall_t < 0 || t != fall_t + 1) begin
      failures++;
      $display("FAIL write_done ok=%0d done_at=%0d busy_fall_at=%0d want done one cycle after fall", ok, t, fall_t);
    end
    repeat (3) tick();
    checks++;
    if (n_wr != 1 || n_rd != 0 || n_done1 != 1 || n_done0 != 0 || p1_err !== 1'b0) begin
      failures++;
      $display("FAIL write_counts wr=%0d rd=%0d done1=%0d done0=%0d want 1 0 1 0", n_wr, n_rd, n_done1, n_done0);
    end
  endtask

  task automatic test_arbitration();
    int rem0; int rem1; int exp_o[8];
`ifdef SDRAM_ARB_RR_EN
    exp_o = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_o = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    reset_dut();
    m_rdata = 16'h5A5A;
    rem0 = 4; rem1 = 4;
    p0_we = 1'b0; p0_addr = 24'h000100; p0_req = 1'b1;
    p1_we = 1'b0; p1_addr = 24'h000200; p1_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (p0_gnt) begin rem0--; if (rem0 == 0) p0_req = 1'b0; end
      if (p1_gnt) begin rem1--; if (rem1 == 0) p1_req = 1'b0; end
      if (n_done0 + n_done1 == 8) break;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    checks++;
    if (order.size() != 8 || n_done0 != 4 || n_done1 != 4) begin
      failures++;
      $display("FAIL arb_count grants=%0d done0=%0d done1=%0d want 8 4 4", order.size(), n_done0, n_done1);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (order[k] != exp_o[k]) begin
          failures++;
          $display("FAIL arb_order idx=%0d got=%0d want=%0d", k, order[k], exp_o[k]);
        end
      end
    end
  endtask

  task automatic test_busy_block();
    int bad; bit ok; int n;
    reset_dut();
    m_rdata = 16'h1111;
    force_busy = 1'b1;
    p0_we = 1'b0; p0_addr = 24'h000333; p0_req = 1'b1;
    bad = 0;
    repeat (200) begin
      tick();
      if (p0_gnt || p1_gnt || m_read_req || m_write_req) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_block issued_cycles=%0d want 0", bad);
    end
    force_busy = 1'b0;
    tick();
    checks++;
    if (p0_gnt !== 1'b1 || m_read_req !== 1'b1 || m_addr !== 24'h000333) begin
      failures++;
      $display("FAIL busy_release gnt=%b rd=%b addr=%h want 1 1 000333", p0_gnt, m_read_req, m_addr);
    end
    p0_req = 1'b0;
    wait_for(2, 30, ok, n);
    checks++;
    if (!ok || p0_rdata !== 16'h1111) begin
      failures++;
      $display("FAIL busy_done ok=%0d rdata=%h want 1 1111", ok, p0_rdata);
    end
  endtask

  task automatic test_watchdog();
    bit ok; int n;
    reset_dut();
    m_rdata = 16'hDEAD;
    hang = 1'b1;
    p0_we = 1'b0; p0_addr = 24'h000444; p0_req = 1'b1;
    wait_for(0, 20, ok, n);
    p0_req = 1'b0;
    wait_for(2, 40, ok, n);
    checks++;
    if (!ok || n != 15 || p0_err !== 1'b1 || p0_rdata !== 16'h0) begin
      failures++;
      $display("FAIL wdog_abort ok=%0d cycles=%0d err=%b rdata=%h want 1 15 1 0000", ok, n, p0_err, p0_rdata);
    end
    tick();
    checks++;
    if (p0_done !== 1'b0 || p0_err !== 1'b0) begin
      failures++;
      $display("FAIL wdog_pulse done=%b err=%b want 0 0", p0_done, p0_err);
    end
    hang = 1'b0;
    repeat (10) tick();
    checks++;
    if (n_done0 != 1 || p0_rdata !== 16'h0) begin
      failures++;
      $display("FAIL wdog_late_ready done0=%0d rdata=%h want 1 0000", n_done0, p0_rdata);
    end
    p1_we = 1'b1; p1_addr = 24'h000555; p1_wdata = 16'h0F0F; p1_req = 1'b1;
    wait_for(1, 10, ok, n);
    p1_req = 1'b0;
    if (ok) wait_for(3, 30, ok, n);
    checks++;
    if (!ok || p1_err !== 1'b0) begin
      failures++;
      $display("FAIL wdog_idle_after ok=%0d err=%b want 1 0", ok, p1_err);
    end
  endtask

  task automatic test_ready_vs_expiry();
    bit ok; int n;
    reset_dut();
    mdl_lat = 13;
    m_rdata = 16'h7E57;
    p0_we = 1'b0; p0_addr = 24'h000666; p0_req = 1'b1;
    wait_for(0, 20, ok, n);
    p0_req = 1'b0;
    wait_for(2, 40, ok, n);
    checks++;
    if (!ok || n != 15 || p0_err !== 1'b0 || p0_rdata !== 16'h7E57) begin
      failures++;
      $display("FAIL ready_vs_expiry ok=%0d cycles=%0d err=%b rdata=%h want 1 15 0 7e57", ok, n, p0_err, p0_rdata);
    end
    repeat (4) tick();
    checks++;
    if (n_done0 != 1) begin
      failures++;
      $display("FAIL ready_vs_expiry_once done0=%0d want 1", n_done0);
    end
    mdl_lat = 3;
  endtask

  task automatic test_reset_mid_access();
    bit ok; int n;
    reset_dut();
    m_rdata = 16'h1234;
    p0_we = 1'b0; p0_addr = 24'h000777; p0_req = 1'b1;
    wait_for(0, 20, ok, n);
    p0_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err, m_read_req, m_write_req} !== 8'h00
        || m_addr !== 24'h0 || p0_rdata !== 16'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs ctrl=%b addr=%h rdata=%h want 0",
               {p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err, m_read_req, m_write_req}, m_addr, p0_rdata);
    end
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (n_done0 != 0 || p0_rdata !== 16'h0 || p0_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_discard done0=%0d rdata=%h err=%b want 0 0000 0", n_done0, p0_rdata, p0_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    m_rdata = '0;
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_busy_block();
    test_watchdog();
    test_ready_vs_expiry();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
